// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the fetch stage.
//   PC_WIDTH : default fetch address width in bits
//   PC_RESET : default fetch address loaded on reset
//   PC_INC   : sequential increment between consecutive fetches
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int          PC_WIDTH = 32;
    localparam logic [31:0] PC_RESET = 32'h00400020;
    localparam int          PC_INC   = 4;

endpackage : mips_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter. It clears on reset. It increments on each cycle
// with inc=1 and then holds at all-ones.
// Ports:
//   clk   : clock, all updates on posedge
//   reset : synchronous active-high clear
//   inc   : count this cycle
//   count : registered count value (W bits)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/fetch_pc_stage.sv
// ---------------------------------------------------------------------------
// fetch_pc_stage
// Fetch-stage PC register. It supports reset to a programmable vector, true
// stall (hold), flush as a bubble, and branch/jump redirect. A redirect that
// arrives while stalled is buffered and applied on the first unstalled cycle.
// A saturating counter records the number of stall cycles for performance
// debug.
// Ports:
//   clk            : clock, all updates on posedge
//   reset          : synchronous active-high reset
//   stall          : 1 = hold current PC
//   flush          : 1 = bubble (valid_out low next cycle)
//   redirect_valid : branch/jump taken this cycle
//   redirect_pc    : redirect target, loaded verbatim (no alignment check)
//   pc_out         : registered current fetch address
//   pc_plus_out    : pc_out + INC, combinational, wraps modulo 2^WIDTH
//   valid_out      : registered; 1 = pc_out is a live fetch
//   pend_out       : registered; 1 = a redirect is buffered
//   stall_cycles   : registered saturating count of stall cycles
//
// Output qualification: valid_out is a pure valid with no ready. The consumer
// must accept every cycle. pc_out is meaningful only when valid_out=1.
// ---------------------------------------------------------------------------
module fetch_pc_stage
    import mips_pkg::*;
#(
    parameter int               WIDTH    = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET),
    parameter int               INC      = PC_INC,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus_out,
    output logic             valid_out,
    output logic             pend_out,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [WIDTH-1:0] pc;
    logic             valid;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_pc;

    // The branches below are in priority order. Flush takes precedence over
    // stall, so a flush cycle always drops any buffered redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            valid      <= 1'b1;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else if (flush) begin
            valid      <= 1'b0;
            pend_valid <= 1'b0;
        end else if (stall) begin
            // Newest redirect overwrites any older buffered one.
            if (redirect_valid) begin
                pend_valid <= 1'b1;
                pend_pc    <= redirect_pc;
            end
        end else if (redirect_valid) begin
            // A live redirect beats a buffered one.
            pc         <= redirect_pc;
            valid      <= 1'b1;
            pend_valid <= 1'b0;
        end else if (pend_valid) begin
            pc         <= pend_pc;
            valid      <= 1'b1;
            pend_valid <= 1'b0;
        end else begin
            pc    <= pc + WIDTH'(INC);
            valid <= 1'b1;
        end
    end

    // Stall cycles count independently of flush.
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .count (stall_cycles)
    );

    assign pc_out      = pc;
    assign pc_plus_out = pc + WIDTH'(INC);
    assign valid_out   = valid;
    assign pend_out    = pend_valid;

endmodule : fetch_pc_stage

// File: tb/tb_fetch_pc_stage.sv
module tb_fetch_pc_stage;

  localparam int          W     = 32;
  localparam int          INC   = 4;
  localparam int          CNT_W = 3;
  localparam logic [31:0] RST   = 32'h00400020;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [W-1:0]     pc;
    logic             valid;
    logic             pend;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             redirect_valid = 1'b0;
  logic [W-1:0]     redirect_pc = '0;
  logic [W-1:0]     pc_out;
  logic [W-1:0]     pc_plus_out;
  logic             valid_out;
  logic             pend_out;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  fetch_pc_stage #(
    .WIDTH    (W),
    .RESET_PC (RST),
    .INC      (INC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_out         (pc_out),
    .pc_plus_out    (pc_plus_out),
    .valid_out      (valid_out),
    .pend_out       (pend_out),
    .stall_cycles   (stall_cycles)
  );

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural state of the fetch PC, advanced once per clock by the
  // priority rules: reset, flush, stall, redirect, pending, sequential.
  logic [W-1:0] m_pc    = '0;
  logic         m_valid = 1'b0;
  logic         m_pend  = 1'b0;
  logic [W-1:0] m_ppc   = '0;
  int           m_cnt   = 0;

  task automatic model_update(input logic r, input logic s, input logic f,
                              input logic rv, input logic [W-1:0] rpc);
    if (r) begin
      m_pc = RST; m_valid = 1'b1; m_pend = 1'b0; m_ppc = '0; m_cnt = 0;
    end else begin
      if (s && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (f) begin
        m_valid = 1'b0; m_pend = 1'b0;
      end else if (s) begin
        if (rv) begin m_pend = 1'b1; m_ppc = rpc; end
      end else if (rv) begin
        m_pc = rpc; m_valid = 1'b1; m_pend = 1'b0;
      end else if (m_pend) begin
        m_pc = m_ppc; m_valid = 1'b1; m_pend = 1'b0;
      end else begin
        m_pc = m_pc + INC; m_valid = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [W-1:0] e_plus;
      e = exp_q.pop_front();
      e_plus = e.pc + INC;
      check("pc_out",       pc_out,                 e.pc);
      check("pc_plus_out",  pc_plus_out,            e_plus);
      check("valid_out",    W'(valid_out),          W'(e.valid));
      check("pend_out",     W'(pend_out),           W'(e.pend));
      check("stall_cycles", W'(stall_cycles),       W'(e.cnt));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic s, input logic f,
                      input logic rv, input logic [W-1:0] rpc);
    exp_t e;
    reset = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    model_update(r, s, f, rv, rpc);
    e.pc = m_pc; e.valid = m_valid; e.pend = m_pend; e.cnt = CNT_W'(m_cnt);
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Reset then free run.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("rst_pc", pc_out, 32'h00400020);
    check("rst_cnt", W'(stall_cycles), '0);
    idle(3);
    check("free_pc3", pc_out, 32'h0040002C);

    // Redirect without stall.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h00400100);
    check("redir_pc", pc_out, 32'h00400100);
    idle(1);
    check("redir_next", pc_out, 32'h00400104);

    // Stall with two redirects; newest wins on release.
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h00400200);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h00400300);
    check("stall_hold", pc_out, 32'h00400104);
    check("stall_pend", W'(pend_out), W'(1));
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    check("release_pc", pc_out, 32'h00400300);
    check("release_cnt", W'(stall_cycles), W'(4));

    // Flush with simultaneous redirect at pc=00400040.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h00400040);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h00400500);
    check("flush_valid", W'(valid_out), '0);
    check("flush_pc", pc_out, 32'h00400040);
    idle(1);
    check("after_flush", pc_out, 32'h00400044);

    // Pending redirect lost by reset during stall.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h00400800);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("rst_mid_pc", pc_out, 32'h00400020);
    check("rst_mid_pend", W'(pend_out), '0);

    // Wrap and counter saturation.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
    idle(1);
    check("wrap_pc", pc_out, 32'h00000000);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("sat_cnt", W'(stall_cycles), W'(7));

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      logic r, s, f, rv;
      logic [W-1:0] rpc;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 30);
      f   = ($urandom_range(0, 99) < 10);
      rv  = ($urandom_range(0, 99) < 25);
      rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 | W'($urandom_range(0, 15)))
                                        : $urandom;
      step(r, s, f, rv, rpc);
    end

    idle(2);
    check("queue_drained", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_pc_stage

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Parametrised fetch-stage PC register: it holds the current fetch address and advances it by a fixed increment each cycle. It adds synchronous reset to a programmable vector, true stall (hold, not zero), flush as a bubble, and branch/jump redirect. A redirect that arrives during a stall is buffered and applied when the stall drops. A saturating stall-cycle counter is provided for performance debug. The block sits at the head of the fetch stage, feeding instruction memory and the F/D pipeline register.

## Interface
Parameters:
- WIDTH, 32, address width in bits
- RESET_PC, 32'h00400020, fetch address loaded on reset
- INC, 4, sequential increment per advance
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- reset  in  1  synchronous, active-high reset
- stall  in  1  from hazard unit; 1 = hold current PC
- flush  in  1  from hazard unit; 1 = insert bubble (valid_out low next cycle)
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  WIDTH  target address, sampled when redirect_valid=1
- pc_out  out  WIDTH  registered current fetch address
- pc_plus_out  out  WIDTH  pc_out + INC, combinational, modulo 2^WIDTH
- valid_out  out  1  registered; 1 = pc_out is a live fetch
- pend_out  out  1  registered; 1 = a redirect is buffered
- stall_cycles  out  CNT_W  registered saturating count of cycles with stall=1

## Operation
- Internal state: pc, valid, pend_valid, pend_pc, stall counter.
- Per posedge, one rule applies, in priority order:
  1. reset: pc=RESET_PC, valid=1, pend_valid=0, pend_pc=0, counter=0.
  2. flush: pc holds, valid=0, pend_valid=0. Any same-cycle redirect is discarded.
  3. stall & redirect_valid: pc and valid hold; pend_pc=redirect_pc, pend_valid=1. If a redirect is already pending, the newest overwrites it.
  4. stall only: all of pc, valid and pending state hold.
  5. redirect_valid (no stall): pc=redirect_pc, valid=1, pend_valid=0. A live redirect beats a buffered one.
  6. pend_valid (no stall, no redirect): pc=pend_pc, valid=1, pend_valid=0.
  7. otherwise: pc=pc+INC, wrapping modulo 2^WIDTH; valid=1.
- Counter rule:
  - Not in reset and stall=1: counter increments, saturating at all-ones.
  - Flush does not affect the counter.
- No alignment check on redirect_pc; it is loaded verbatim.

## Timing
- All outputs except pc_plus_out are registered; there is no combinational path from inputs to pc_out or valid_out.
- Latency:
  - redirect (no stall) reaches pc_out 1 cycle later.
  - A buffered redirect reaches pc_out 1 cycle after the first stall=0 cycle.
- After reset deasserts: pc_out=RESET_PC and valid_out=1 in the first cycle, then RESET_PC+INC in the next.
- Flush is a single-cycle bubble:
  - valid_out=0 for exactly one cycle per flush cycle.
  - pc_out is unchanged, so the next non-stall, non-flush cycle fetches pc+INC.
- Reset mid-stall or with a pending redirect: the pending redirect is lost and pc_out=RESET_PC next cycle.
- Boundary cases:
  - stall held for 2^CNT_W or more cycles: stall_cycles stays at all-ones.
  - pc = 2^WIDTH-INC: the next advance yields 0.

## Structure
- Shared package mips_pkg holds:
  - default WIDTH
  - default RESET_PC (32'h00400020)
  - PC_INC constant
- The stall counter is the natural sub-module: sat_counter, with parameter W and ports clk, reset, inc, count.
- All other logic is one always block plus the pc_plus_out adder.

## Test plan
- Reset, then 3 free-run cycles -> pc_out 00400020, 00400024, 00400028, 0040002C; valid_out=1 throughout; stall_cycles=0.
- Redirect to 00400100 with stall=0 -> next cycle pc_out=00400100, then 00400104.
- Stall for 4 cycles with redirect 00400200 in stall cycle 2 and 00400300 in stall cycle 3, then release:
  - pc_out holds during the stall.
  - pend_out=1 from stall cycle 3 onward.
  - 1 cycle after release, pc_out=00400300 and pend_out=0.
  - stall_cycles=4.
- Flush with simultaneous redirect at pc=00400040 -> next cycle valid_out=0, pc_out=00400040, redirect discarded; following cycle pc_out=00400044, valid_out=1.
- Pending redirect, then reset asserted while stall=1 -> next cycle pc_out=00400020, pend_out=0, stall_cycles=0.
- Wrap and saturation, with CNT_W=3 and pc at FFFFFFFC:
  - Advance -> pc_out=00000000.
  - Stall 10 cycles -> stall_cycles saturates at 7.
